alu_top: RTL and testbench

Single-bit ALU slice with registered outputs, intended to be replicated per bit and chained through `c_in` to form an N-bit datapath ALU. It supports AND, OR, add, and set-less-than pass-through on optionally inverted operands. It also produces the signed-compare `set` bit and the overflow flag used by the most-significant slice. All outputs are captured in flip-flops on a single clock, with synchronous active-high reset.

---
 rtl/alu_top.sv | 87 ++++++++
 tb/tb_alu_top.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
// Module   : alu_top
// Purpose  : Registered single-bit ALU slice (AND/OR/SLT/ADD) with signed
//            less-than and overflow outputs for the most-significant slice.
// Revision : 1.0  initial release
// ============================================================================
module alu_top (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       sm,
    input  logic       sa,
    input  logic       sb,
    input  logic       c_in,
    input  logic [1:0] op,
    output logic       result,
    output logic       set,
    output logic       ovf
);

    localparam logic [1:0] c_OP_AND = 2'b00;
    localparam logic [1:0] c_OP_OR  = 2'b01;
    localparam logic [1:0] c_OP_SLT = 2'b10;
    localparam logic [1:0] c_OP_ADD = 2'b11;

    logic w_aa;
    logic w_bb;
    logic w_sum;
    logic w_cout;
    logic w_ovf_raw;
    logic w_result;
    logic w_ovf;
    logic w_set;

    logic r_result;
    logic r_set;
    logic r_ovf;

    assign w_aa      = a ^ sa;
    assign w_bb      = b ^ sb;
    assign w_sum     = w_aa ^ w_bb ^ c_in;
    assign w_cout    = (w_aa & w_bb) | (w_aa & c_in) | (w_bb & c_in);
    assign w_ovf_raw = c_in ^ w_cout;
    // Sign of the true (unoverflowed) result: correct signed less-than.
    assign w_set     = w_sum ^ w_ovf_raw;

    always_comb begin
        w_result = 1'b0;
        w_ovf    = 1'b0;
        case (op)
            c_OP_AND: w_result = w_aa & w_bb;
            c_OP_OR:  w_result = w_aa | w_bb;
            c_OP_SLT: begin
                w_result = sm;
                w_ovf    = w_ovf_raw;
            end
            c_OP_ADD: begin
                w_result = w_sum;
                w_ovf    = w_ovf_raw;
            end
            default: begin
                w_result = 1'b0;
                w_ovf    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 1'b0;
            r_set    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_set    <= w_set;
            r_ovf    <= w_ovf;
        end
    end

    assign result = r_result;
    assign set    = r_set;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_top
// Purpose  : Directed self-checking bench for the alu_top bit slice.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_top;

    logic       clk;
    logic       rst;
    logic       a;
    logic       b;
    logic       sm;
    logic       sa;
    logic       sb;
    logic       c_in;
    logic [1:0] op;
    logic       result;
    logic       set;
    logic       ovf;

    int n_cmp;
    int n_bad;

    alu_top dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .sm     (sm),
        .sa     (sa),
        .sb     (sb),
        .c_in   (c_in),
        .op     (op),
        .result (result),
        .set    (set),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 1 ns after rising.
    task automatic drive(input logic ia, input logic ib, input logic ic,
                         input logic [1:0] iop, input logic isa, input logic isb,
                         input logic ism, input logic irst);
        @(negedge clk);
        a = ia; b = ib; c_in = ic; op = iop; sa = isa; sb = isb; sm = ism; rst = irst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({result, set, ovf} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset: got r/s/o=%b%b%b want 000", result, set, ovf);
        end
    endtask

    task automatic test_add();
        logic [2:0] vin [5];
        logic [2:0] vexp [5];   // {result, ovf, set}
        vin[0] = 3'b000; vexp[0] = 3'b000;
        vin[1] = 3'b010; vexp[1] = 3'b101;
        vin[2] = 3'b011; vexp[2] = 3'b000;
        vin[3] = 3'b110; vexp[3] = 3'b011;
        vin[4] = 3'b111; vexp[4] = 3'b101;
        for (int i = 0; i < 5; i++) begin
            drive(vin[i][2], vin[i][1], vin[i][0], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({result, ovf, set} !== vexp[i]) begin
                n_bad++;
                $display("FAIL add[%0d] abc=%b: got r/o/s=%b%b%b want %b",
                         i, vin[i], result, ovf, set, vexp[i]);
            end
        end
    endtask

    task automatic test_logic();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf} !== 2'b00) begin
            n_bad++;
            $display("FAIL and: got r/o=%b%b want 00", result, ovf);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf} !== 2'b10) begin
            n_bad++;
            $display("FAIL or: got r/o=%b%b want 10", result, ovf);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf} !== 2'b10) begin
            n_bad++;
            $display("FAIL nor: got r/o=%b%b want 10", result, ovf);
        end
        // OR of inverted operands (NAND) with a carry that would overflow an add
        drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf} !== 2'b00) begin
            n_bad++;
            $display("FAIL nand: got r/o=%b%b want 00", result, ovf);
        end
    endtask

    task automatic test_slt();
        // aa=0 bb=0 cin=1: sum=1 cout=0 ovf_raw=1 -> set=0, ovf=1 for SLT
        drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if ({result, ovf, set} !== 3'b110) begin
            n_bad++;
            $display("FAIL slt_ovf: got r/o/s=%b%b%b want 110", result, ovf, set);
        end
        // aa=1 bb=0 cin=0: sum=1 cout=0 ovf_raw=0 -> set=1, ovf=0; sm=0 passes through
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf, set} !== 3'b001) begin
            n_bad++;
            $display("FAIL slt_set: got r/o/s=%b%b%b want 001", result, ovf, set);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        a = 1'b1; b = 1'b1; c_in = 1'b0;
        #3;
        n_cmp++;
        if ({result, ovf, set} !== 3'b101) begin
            n_bad++;
            $display("FAIL hold: got r/o/s=%b%b%b want 101", result, ovf, set);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({result, ovf, set} !== 3'b011) begin
            n_bad++;
            $display("FAIL hold_next: got r/o/s=%b%b%b want 011", result, ovf, set);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({result, ovf, set} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid: got r/o/s=%b%b%b want 000", result, ovf, set);
        end
        drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({result, ovf, set} !== 3'b011) begin
            n_bad++;
            $display("FAIL reset_mid_next: got r/o/s=%b%b%b want 011", result, ovf, set);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; a = 1'b0; b = 1'b0; sm = 1'b0; sa = 1'b0; sb = 1'b0;
        c_in = 1'b0; op = 2'b00;
        test_reset();
        test_add();
        test_logic();
        test_slt();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
